// File: rtl/psg_pkg.sv
// Shared definitions for the multi-channel PSG: bus cycle encoding,
// register offsets within a channel block, control bit positions and LFSR setup.
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        ADDR  = 2'b11
    } bus_cycle_t;

    localparam logic [1:0] OFS_PER_LO = 2'd0;
    localparam logic [1:0] OFS_PER_HI = 2'd1;
    localparam logic [1:0] OFS_VOL    = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    localparam int CTRL_TONE  = 0;
    localparam int CTRL_NOISE = 1;
    localparam int CTRL_PAN_L = 2;
    localparam int CTRL_PAN_R = 3;

    localparam int              LFSR_W    = 17;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h00001;

endpackage

// File: rtl/psg_tone_ch.sv
// One tone channel: period counter and square bit advanced on prescaler ticks,
// plus the tone/noise gate that turns the channel volume into its output level.
module psg_tone_ch #(
    parameter int TONE_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [TONE_W-1:0] period,
    input  logic [3:0]        volume,
    input  logic              tone_en,
    input  logic              noise_en,
    input  logic              noise_out,
    output logic [3:0]        level
);

    logic [TONE_W-1:0] cnt;
    logic [TONE_W-1:0] limit;
    logic              square;
    logic              gate;

    // Period 0 behaves as 1; the >= compare also catches a period lowered below cnt.
    assign limit = (period == '0) ? '0 : period - TONE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            square <= 1'b0;
        end else if (tick) begin
            if (cnt >= limit) begin
                cnt    <= '0;
                square <= ~square;
            end else begin
                cnt <= cnt + TONE_W'(1);
            end
        end
    end

    assign gate  = (square | ~tone_en) & (noise_out | ~noise_en);
    assign level = gate ? volume : 4'd0;

endmodule

// File: rtl/psg_multi.sv
// Multi-channel PSG top: bus register file, prescaler, noise LFSR and stereo mixer.
// Define PSG_MULTI_NOISE_EN to build the noise generator; otherwise noise_out is tied high.
module psg_multi
    import psg_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int TONE_W = 12,
    parameter int OUT_W  = 4 + $clog2(NUM_CH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    input  logic              BDIR,
    input  logic              BC,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    output logic [OUT_W-1:0]  LEFT,
    output logic [OUT_W-1:0]  RIGHT,
    output logic [NUM_CH-1:0] ACTIVE
);

    bus_cycle_t cyc;
    logic [5:0] addr;
    logic [3:0] addr_ch;
    logic [1:0] addr_ofs;
    logic [7:0] rd_data;

    logic [TONE_W-1:0] period [NUM_CH];
    logic [3:0]        volume [NUM_CH];
    logic [3:0]        ctrl   [NUM_CH];
    logic [3:0]        level  [NUM_CH];

    logic [2:0] presc;
    logic       tick;
    logic       noise_out;

    logic [OUT_W-1:0]  sum_l;
    logic [OUT_W-1:0]  sum_r;
    logic [NUM_CH-1:0] act;

    assign cyc      = bus_cycle_t'({BDIR, BC});
    assign addr_ch  = addr[5:2];
    assign addr_ofs = addr[1:0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                volume[i] <= '0;
                ctrl[i]   <= '0;
            end
        end else begin
            if (cyc == ADDR)
                addr <= DI[5:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (cyc == WRITE && addr_ch == 4'(i)) begin
                    case (addr_ofs)
                        OFS_PER_LO: period[i][7:0]        <= DI;
                        OFS_PER_HI: period[i][TONE_W-1:8] <= DI[TONE_W-9:0];
                        OFS_VOL:    volume[i]             <= DI[3:0];
                        default:    ctrl[i]               <= DI[3:0];
                    endcase
                end
            end
        end
    end

`ifdef PSG_MULTI_NOISE_EN
    localparam logic [5:0] NOISE_ADDR = 6'(4 * NUM_CH);

    logic [4:0]        noise_per;
    logic [4:0]        noise_cnt;
    logic [4:0]        noise_lim;
    logic [LFSR_W-1:0] lfsr;

    assign noise_lim = (noise_per == '0) ? '0 : noise_per - 5'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            noise_per <= '0;
            noise_cnt <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            if (cyc == WRITE && addr == NOISE_ADDR)
                noise_per <= DI[4:0];
            if (tick) begin
                if (noise_cnt >= noise_lim) begin
                    noise_cnt <= '0;
                    lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[LFSR_W-1:1]};
                end else begin
                    noise_cnt <= noise_cnt + 5'd1;
                end
            end
        end
    end

    assign noise_out = lfsr[0];
`else
    assign noise_out = 1'b1;
`endif

    // Channel index match implies the address lies inside the channel blocks.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ch == 4'(i)) begin
                case (addr_ofs)
                    OFS_PER_LO: rd_data = period[i][7:0];
                    OFS_PER_HI: rd_data = 8'(period[i][TONE_W-1:8]);
                    OFS_VOL:    rd_data = 8'(volume[i]);
                    default:    rd_data = 8'(ctrl[i]);
                endcase
            end
        end
`ifdef PSG_MULTI_NOISE_EN
        if (addr == NOISE_ADDR)
            rd_data = 8'(noise_per);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            DO <= 8'h00;
        else if (cyc == READ)
            DO <= rd_data;
    end

    assign tick = CE & (presc == 3'd7);

    always_ff @(posedge CLK) begin
        if (RESET)
            presc <= '0;
        else if (CE)
            presc <= presc + 3'd1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        psg_tone_ch #(
            .TONE_W (TONE_W)
        ) u_ch (
            .clk       (CLK),
            .reset     (RESET),
            .tick      (tick),
            .period    (period[g]),
            .volume    (volume[g]),
            .tone_en   (ctrl[g][CTRL_TONE]),
            .noise_en  (ctrl[g][CTRL_NOISE]),
            .noise_out (noise_out),
            .level     (level[g])
        );
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        act   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ctrl[i][CTRL_PAN_L])
                sum_l = sum_l + OUT_W'(level[i]);
            if (ctrl[i][CTRL_PAN_R])
                sum_r = sum_r + OUT_W'(level[i]);
            act[i] = (level[i] != 4'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            LEFT   <= '0;
            RIGHT  <= '0;
            ACTIVE <= '0;
        end else if (CE) begin
            LEFT   <= sum_l;
            RIGHT  <= sum_r;
            ACTIVE <= act;
        end
    end

endmodule
